// File: rtl/lc2k_multicycle_ctrl.sv
// LC2K multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with a
// req/ready handshake to a single shared instruction/data memory port.
// Optional performance counters are enabled by defining LC2K_CTRL_PERF_EN;
// without it, cycle_cnt/instr_cnt are tied to zero and no counter flops exist.
module lc2k_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             alu_eq,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             ab_load,
  output logic             aluout_load,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             alu_srcB,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic             reg_dst,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  logic [2:0] state, state_nxt;

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Output decode and next-state logic. All outputs are forced low while rst
  // is high so an in-flight memory request drops in the same cycle.
  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    ab_load      = 1'b0;
    aluout_load  = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 2'd0;
    alu_srcB     = 1'b0;
    alu_op       = 2'd0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load   = 1'b1;
            pc_load   = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          ab_load = 1'b1;
          case (opcode)
            OP_HALT: state_nxt = S_HALT;
            OP_NOOP: state_nxt = S_FETCH;
            default: state_nxt = S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_NOR: begin
              alu_srcB    = 1'b1;
              alu_op      = (opcode == OP_NOR) ? 2'd1 : 2'd0;
              aluout_load = 1'b1;
              state_nxt   = S_WB;
            end
            OP_LW, OP_SW: begin
              aluout_load = 1'b1;
              state_nxt   = S_MEM;
            end
            OP_BEQ: begin
              alu_op   = 2'd2;
              alu_srcB = 1'b1;
              if (alu_eq) begin
                pc_load = 1'b1;
                pc_src  = 2'd1;
              end
              state_nxt = S_FETCH;
            end
            OP_JALR: begin
              // Link PC+1 into regB and jump to regA latched in DECODE.
              reg_we    = 1'b1;
              wb_sel    = 2'd2;
              pc_load   = 1'b1;
              pc_src    = 2'd2;
              state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_SW);
          if (mem_ready) begin
            if (opcode == OP_SW) begin
              state_nxt = S_FETCH;
            end else begin
              mdr_load  = 1'b1;
              state_nxt = S_WB;
            end
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          if (opcode != OP_LW) begin
            reg_dst = 1'b1;
            wb_sel  = 2'd1;
          end
          state_nxt = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

`ifdef LC2K_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cyc_q, ins_q;

  // Saturating perf counters; both freeze once the core has halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state != S_HALT && cyc_q != CNT_MAX) cyc_q <= cyc_q + CNT_ONE;
      if (state == S_DECODE && ins_q != CNT_MAX) ins_q <= ins_q + CNT_ONE;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Self-checking bench for lc2k_multicycle_ctrl. Each cycle's expected output
// vector is queued when the stimulus is applied and popped when sampled.
module tb_lc2k_multicycle_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       opcode = 3'd0;
  logic             alu_eq = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, ab_load;
  logic             aluout_load, pc_load, alu_srcB, reg_we, reg_dst, halted;
  logic [1:0]       pc_src, alu_op, wb_sel;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  lc2k_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_eq(alu_eq), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .mdr_load(mdr_load), .ab_load(ab_load),
    .aluout_load(aluout_load), .pc_load(pc_load), .pc_src(pc_src),
    .alu_srcB(alu_srcB), .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Packed view of every control output.
  logic [17:0] outs;
  assign outs = {mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, ab_load,
                 aluout_load, pc_load, pc_src, alu_srcB, alu_op, reg_we,
                 reg_dst, wb_sel, halted};

  localparam logic [17:0] B_REQ   = 18'd1 << 17;
  localparam logic [17:0] B_WE    = 18'd1 << 16;
  localparam logic [17:0] B_ASEL  = 18'd1 << 15;
  localparam logic [17:0] B_IR    = 18'd1 << 14;
  localparam logic [17:0] B_MDR   = 18'd1 << 13;
  localparam logic [17:0] B_AB    = 18'd1 << 12;
  localparam logic [17:0] B_ALO   = 18'd1 << 11;
  localparam logic [17:0] B_PCL   = 18'd1 << 10;
  localparam logic [17:0] PCS_OFF = 18'd1 << 8;
  localparam logic [17:0] PCS_A   = 18'd2 << 8;
  localparam logic [17:0] B_SRCB  = 18'd1 << 7;
  localparam logic [17:0] AOP_NOR = 18'd1 << 5;
  localparam logic [17:0] AOP_EQ  = 18'd2 << 5;
  localparam logic [17:0] B_RWE   = 18'd1 << 4;
  localparam logic [17:0] B_RDST  = 18'd1 << 3;
  localparam logic [17:0] WB_ALU  = 18'd1 << 1;
  localparam logic [17:0] WB_PC   = 18'd2 << 1;
  localparam logic [17:0] B_HLT   = 18'd1;

  localparam logic [17:0] F_WAIT   = B_REQ;
  localparam logic [17:0] F_RDY    = B_REQ | B_IR | B_PCL;
  localparam logic [17:0] DEC      = B_AB;
  localparam logic [17:0] EX_ADD   = B_SRCB | B_ALO;
  localparam logic [17:0] EX_NOR   = B_SRCB | B_ALO | AOP_NOR;
  localparam logic [17:0] EX_LS    = B_ALO;
  localparam logic [17:0] EX_BEQ_T = AOP_EQ | B_SRCB | B_PCL | PCS_OFF;
  localparam logic [17:0] EX_BEQ_F = AOP_EQ | B_SRCB;
  localparam logic [17:0] EX_JALR  = B_RWE | WB_PC | B_PCL | PCS_A;
  localparam logic [17:0] MEM_LW_W = B_REQ | B_ASEL;
  localparam logic [17:0] MEM_LW_R = B_REQ | B_ASEL | B_MDR;
  localparam logic [17:0] MEM_SW   = B_REQ | B_WE | B_ASEL;
  localparam logic [17:0] WB_AN    = B_RWE | B_RDST | WB_ALU;
  localparam logic [17:0] WB_LW    = B_RWE;
  localparam logic [17:0] HALT_O   = B_HLT;

  localparam logic [2:0] OP_ADD = 3'd0, OP_NOR = 3'd1, OP_LW = 3'd2, OP_SW = 3'd3;
  localparam logic [2:0] OP_BEQ = 3'd4, OP_JALR = 3'd5, OP_HALT = 3'd6, OP_NOOP = 3'd7;

  logic [17:0] exp_q [$];
  int n_pass = 0;
  int n_tot  = 0;

  // One stimulus step: {opcode, alu_eq, mem_ready, expected outputs}.
  function automatic logic [22:0] st(input logic [2:0] op, input logic eq,
                                     input logic rdy, input logic [17:0] e);
    return {op, eq, rdy, e};
  endfunction

  // Apply a step after the falling edge and queue its expected outputs.
  task automatic drive(input logic [22:0] v);
    @(negedge clk);
    opcode    = v[22:20];
    alu_eq    = v[19];
    mem_ready = v[18];
    exp_q.push_back(v[17:0]);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Outputs zero during reset; FETCH right after release. Leaves the first
  // fetch completing so the halt scenario starts in DECODE.
  task automatic test_reset();
    logic [17:0] e;
    @(negedge clk);
    #1;
    n_tot++;
    if (outs !== 18'd0 || cycle_cnt !== '0 || instr_cnt !== '0)
      $display("FAIL reset_hold: outs=%h cyc=%0d ins=%0d expected 0/0/0", outs, cycle_cnt, instr_cnt);
    else n_pass++;
    rst = 1'b0;
    mem_ready = 1'b0;
    exp_q.push_back(F_WAIT);
    #1;
    e = exp_q.pop_front();
    n_tot++;
    if (outs !== e) $display("FAIL reset_fetch_wait: outs=%h expected %h", outs, e);
    else n_pass++;
    opcode = OP_HALT;
    mem_ready = 1'b1;
    exp_q.push_back(F_RDY);
    #1;
    e = exp_q.pop_front();
    n_tot++;
    if (outs !== e) $display("FAIL reset_fetch_rdy: outs=%h expected %h", outs, e);
    else n_pass++;
  endtask

  task automatic test_halt();
    logic [22:0] s [$];
    logic [17:0] e;
    logic [CNT_W-1:0] ecyc, eins;
    s.push_back(st(OP_HALT, 1'b0, 1'b1, DEC));
    for (int i = 0; i < 20; i++) s.push_back(st(OP_HALT, 1'b0, i[0], HALT_O));
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      n_tot++;
      if (outs !== e) $display("FAIL halt[%0d]: outs=%h expected %h", i, outs, e);
      else n_pass++;
    end
`ifdef LC2K_CTRL_PERF_EN
    ecyc = 2; eins = 1;
`else
    ecyc = 0; eins = 0;
`endif
    n_tot++;
    if (cycle_cnt !== ecyc) $display("FAIL halt_cycle_cnt: got %0d expected %0d", cycle_cnt, ecyc);
    else n_pass++;
    n_tot++;
    if (instr_cnt !== eins) $display("FAIL halt_instr_cnt: got %0d expected %0d", instr_cnt, eins);
    else n_pass++;
  endtask

  task automatic test_alu_ops();
    logic [22:0] s [$];
    logic [17:0] e;
    s = '{st(OP_ADD, 1'b0, 1'b1, F_RDY), st(OP_ADD, 1'b0, 1'b1, DEC),
          st(OP_ADD, 1'b0, 1'b1, EX_ADD), st(OP_ADD, 1'b0, 1'b1, WB_AN),
          st(OP_NOR, 1'b1, 1'b1, F_RDY), st(OP_NOR, 1'b1, 1'b1, DEC),
          st(OP_NOR, 1'b1, 1'b1, EX_NOR), st(OP_NOR, 1'b1, 1'b1, WB_AN)};
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      n_tot++;
      if (outs !== e) $display("FAIL alu_ops[%0d]: outs=%h expected %h", i, outs, e);
      else n_pass++;
    end
  endtask

  task automatic test_lw_wait();
    logic [22:0] s [$];
    logic [17:0] e;
    s = '{st(OP_LW, 1'b0, 1'b1, F_RDY), st(OP_LW, 1'b0, 1'b1, DEC),
          st(OP_LW, 1'b0, 1'b1, EX_LS), st(OP_LW, 1'b0, 1'b0, MEM_LW_W),
          st(OP_LW, 1'b0, 1'b0, MEM_LW_W), st(OP_LW, 1'b0, 1'b0, MEM_LW_W),
          st(OP_LW, 1'b0, 1'b1, MEM_LW_R), st(OP_LW, 1'b0, 1'b1, WB_LW)};
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      n_tot++;
      if (outs !== e) $display("FAIL lw_wait[%0d]: outs=%h expected %h", i, outs, e);
      else n_pass++;
    end
  endtask

  task automatic test_branch_jump();
    logic [22:0] s [$];
    logic [17:0] e;
    s = '{st(OP_BEQ, 1'b1, 1'b1, F_RDY), st(OP_BEQ, 1'b1, 1'b1, DEC),
          st(OP_BEQ, 1'b1, 1'b1, EX_BEQ_T),
          st(OP_BEQ, 1'b0, 1'b1, F_RDY), st(OP_BEQ, 1'b0, 1'b1, DEC),
          st(OP_BEQ, 1'b0, 1'b1, EX_BEQ_F),
          st(OP_JALR, 1'b1, 1'b1, F_RDY), st(OP_JALR, 1'b1, 1'b1, DEC),
          st(OP_JALR, 1'b1, 1'b1, EX_JALR)};
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      n_tot++;
      if (outs !== e) $display("FAIL branch_jump[%0d]: outs=%h expected %h", i, outs, e);
      else n_pass++;
    end
  endtask

  // sw with a slow fetch, then two noops and a stalled fetch, back to back.
  task automatic test_back_to_back();
    logic [22:0] s [$];
    logic [17:0] e;
    s = '{st(OP_SW, 1'b0, 1'b0, F_WAIT), st(OP_SW, 1'b0, 1'b0, F_WAIT),
          st(OP_SW, 1'b0, 1'b1, F_RDY), st(OP_SW, 1'b0, 1'b1, DEC),
          st(OP_SW, 1'b0, 1'b1, EX_LS), st(OP_SW, 1'b0, 1'b1, MEM_SW),
          st(OP_NOOP, 1'b0, 1'b1, F_RDY), st(OP_NOOP, 1'b0, 1'b1, DEC),
          st(OP_NOOP, 1'b0, 1'b1, F_RDY), st(OP_NOOP, 1'b0, 1'b1, DEC),
          st(OP_ADD, 1'b0, 1'b0, F_WAIT)};
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      n_tot++;
      if (outs !== e) $display("FAIL back_to_back[%0d]: outs=%h expected %h", i, outs, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [22:0] s [$];
    logic [17:0] e;
    s = '{st(OP_SW, 1'b0, 1'b1, F_RDY), st(OP_SW, 1'b0, 1'b1, DEC),
          st(OP_SW, 1'b0, 1'b1, EX_LS), st(OP_SW, 1'b0, 1'b0, MEM_SW)};
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      n_tot++;
      if (outs !== e) $display("FAIL rst_mid[%0d]: outs=%h expected %h", i, outs, e);
      else n_pass++;
    end
    #1 rst = 1'b1;
    #1;
    n_tot++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || outs !== 18'd0)
      $display("FAIL rst_mid_drop: req=%b we=%b outs=%h expected all 0", mem_req, mem_we, outs);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    exp_q.push_back(F_WAIT);
    #1;
    e = exp_q.pop_front();
    n_tot++;
    if (outs !== e) $display("FAIL rst_mid_fetch: outs=%h expected %h", outs, e);
    else n_pass++;
    n_tot++;
    if (cycle_cnt !== '0 || instr_cnt !== '0)
      $display("FAIL rst_mid_counters: cyc=%0d ins=%0d expected 0/0", cycle_cnt, instr_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_halt();
    apply_reset();
    test_alu_ops();
    test_lw_wait();
    test_branch_jump();
    test_back_to_back();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/lc2k_multicycle_ctrl.md
Name: lc2k_multicycle_ctrl

Overview:
Multi-cycle sequencer for the LC2K datapath. It drops one instruction through FETCH/DECODE/EXEC/MEM/WB per pass and drives all datapath select and strobe signals. It also runs a req/ready handshake with a single shared instruction/data memory port. It replaces the per-opcode static decode with a state machine, so lw/sw/fetch can share one memory and tolerate variable memory latency.

Parameters:
CNT_W, 32, width of the performance counters (only meaningful with LC2K_CTRL_PERF_EN).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  3  IR[24:22]; add=0 nor=1 lw=2 sw=3 beq=4 jalr=5 halt=6 noop=7; valid from DECODE onward, ignored in FETCH
alu_eq  in  1  datapath comparator: regA value == regB value (latched A/B)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1=write (sw), 0=read
mem_addr_sel  out  1  0=PC, 1=ALUOut
ir_load  out  1  load IR from memory read data
mdr_load  out  1  load MDR from memory read data
ab_load  out  1  latch regfile A/B outputs
aluout_load  out  1  latch ALU result
pc_load  out  1  write PC
pc_src  out  2  0=PC+1, 1=PC+offsetExtended, 2=latched regA
alu_srcB  out  1  1=regB value, 0=offsetExtended
alu_op  out  2  0=add, 1=nor, 2=equal
reg_we  out  1  register file write enable
reg_dst  out  1  1=destReg field, 0=regB field
wb_sel  out  2  0=MDR, 1=ALUOut, 2=PC (already incremented)
halted  out  1  sticky halt indicator
cycle_cnt  out  CNT_W  perf: active cycles
instr_cnt  out  CNT_W  perf: instructions decoded

Behaviour:
- Reset (async): state=FETCH immediately. While rst=1 every output is 0, including mem_req, which drops in the same cycle. Counters clear. The first FETCH cycle is the first clock after rst deasserts.
- All outputs are combinational decode of state, opcode, mem_ready and alu_eq. Any output not listed for a state is 0.
- FETCH: mem_req=1, mem_addr_sel=0. Stay while mem_ready=0. On mem_ready=1: ir_load=1, pc_load=1, pc_src=0; go to DECODE.
- DECODE: ab_load=1. halt -> HALT; noop -> FETCH; otherwise -> EXEC.
- EXEC add/nor: alu_srcB=1, alu_op=0 for add or 1 for nor, aluout_load=1; go to WB.
- EXEC lw/sw: alu_srcB=0, alu_op=0, aluout_load=1; go to MEM.
- EXEC beq: alu_op=2, alu_srcB=1. If alu_eq=1 then pc_load=1, pc_src=1. Go to FETCH.
- EXEC jalr: reg_we=1, reg_dst=0, wb_sel=2, pc_load=1, pc_src=2; go to FETCH.
  - The jump uses the regA value latched in DECODE, so regA==regB jumps to the old regA value.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 iff sw. Hold while mem_ready=0.
  - On mem_ready=1: sw goes to FETCH; lw asserts mdr_load=1 and goes to WB.
- WB: reg_we=1. add/nor: reg_dst=1, wb_sel=1. lw: reg_dst=0, wb_sel=0. Go to FETCH.
- HALT: halted=1 and all strobes 0. Leave only on reset; mem_ready is ignored.
- Handshake: mem_req, mem_we and mem_addr_sel are stable while waiting. mem_ready is ignored when mem_req=0.
- Cycles per instruction with zero-wait memory:
  - noop 2, halt 2 (then idle)
  - beq 3, jalr 3
  - add/nor 4, sw 4
  - lw 5
  - Each wait cycle adds 1 per memory access.

Optional Feature:
Macro LC2K_CTRL_PERF_EN.
- Defined: cycle_cnt increments every clock while not halted and rst=0. instr_cnt increments on every DECODE cycle, halt included. Both saturate at all-ones and freeze in HALT.
- Undefined: cycle_cnt and instr_cnt are tied to 0 and no counter flops exist.

Test Plan:
- add, mem_ready=1 always -> FETCH, DECODE, EXEC (aluout_load=1, alu_op=0, alu_srcB=1), then WB (reg_we=1, reg_dst=1, wb_sel=1). Next FETCH at cycle 5.
- lw, mem_ready low for 3 cycles in MEM -> mem_req=1 and mem_addr_sel=1 held for 4 cycles, mdr_load=1 only on the ready cycle. WB has reg_dst=0, wb_sel=0. Total 8 cycles.
- beq with alu_eq=1, then again with alu_eq=0 -> EXEC shows pc_load=1, pc_src=1 for the first and pc_load=0 for the second. Both are 3 cycles.
- jalr -> EXEC shows reg_we=1, reg_dst=0, wb_sel=2, pc_load=1, pc_src=2 in one cycle, then FETCH.
- halt, then 20 idle cycles with mem_ready toggling -> halted=1, mem_req=0 throughout. With PERF_EN: instr_cnt=1, cycle_cnt=2 (frozen).
- rst pulsed while in MEM for sw with mem_ready=0 -> mem_req and mem_we fall in the same cycle. After release: FETCH, mem_req=1, mem_addr_sel=0, halted=0, counters 0.
